// File: rtl/instr_fetch.sv
// Instruction fetch stage: keeps the PC, issues one read at a time to instruction
// memory, and holds each returned word on a valid/ready interface until decode takes it.
module instr_fetch #(
    parameter int unsigned              ADDRESS_WIDTH = 32,
    parameter logic [ADDRESS_WIDTH-1:0] RESET_PC      = '0
) (
    input  logic                     clk,
    input  logic                     rst,
    output logic                     mem_req,
    output logic [ADDRESS_WIDTH-1:0] mem_addr,
    input  logic                     mem_ack,
    input  logic [31:0]              mem_rdata,
    output logic [31:0]              instr,
    output logic                     instr_valid,
    input  logic                     instr_ready,
    output logic [ADDRESS_WIDTH-1:0] pc_out,
    input  logic                     PCsrc,
    input  logic [ADDRESS_WIDTH-1:0] ImmOp,
    output logic [31:0]              instr_count
);

    localparam int unsigned INSTR_W = 32;
    localparam int unsigned CNT_W   = 32;

    localparam logic [1:0] ST_RST  = 2'd0;
    localparam logic [1:0] ST_WAIT = 2'd1;
    localparam logic [1:0] ST_HOLD = 2'd2;

    logic [1:0]               state_q,    state_d;
    logic [ADDRESS_WIDTH-1:0] fetch_pc_q, fetch_pc_d;
    logic [ADDRESS_WIDTH-1:0] pc_out_q,   pc_out_d;
    logic [ADDRESS_WIDTH-1:0] mem_addr_q, mem_addr_d;
    logic [INSTR_W-1:0]       instr_q,    instr_d;
    logic [CNT_W-1:0]         count_q,    count_d;
    logic                     mem_req_q,  mem_req_d;
    logic                     valid_q,    valid_d;
    logic [ADDRESS_WIDTH-1:0] next_pc;

    // Next-state and datapath; request/valid/address are decoded from the next state
    // so they leave the block as flops that track the state register exactly.
    always_comb begin
        state_d    = state_q;
        fetch_pc_d = fetch_pc_q;
        pc_out_d   = pc_out_q;
        instr_d    = instr_q;
        count_d    = count_q;
        next_pc    = PCsrc ? (pc_out_q + ImmOp) : (pc_out_q + ADDRESS_WIDTH'(4));

        case (state_q)
            ST_RST: begin
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                if (mem_ack) begin
                    instr_d  = mem_rdata;
                    pc_out_d = fetch_pc_q;
                    state_d  = ST_HOLD;
                end
            end
            ST_HOLD: begin
                // instr_valid is high for the whole of HOLD, so ready alone means accept
                if (instr_ready) begin
                    fetch_pc_d = next_pc & ~ADDRESS_WIDTH'(3);
                    count_d    = count_q + CNT_W'(1);
                    state_d    = ST_WAIT;
                end
            end
            default: begin
                state_d = ST_RST;
            end
        endcase

        mem_req_d  = (state_d == ST_WAIT);
        mem_addr_d = mem_req_d ? fetch_pc_d : '0;
        valid_d    = (state_d == ST_HOLD);
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q    <= ST_RST;
            fetch_pc_q <= RESET_PC;
            pc_out_q   <= '0;
            mem_addr_q <= '0;
            instr_q    <= '0;
            count_q    <= '0;
            mem_req_q  <= 1'b0;
            valid_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            fetch_pc_q <= fetch_pc_d;
            pc_out_q   <= pc_out_d;
            mem_addr_q <= mem_addr_d;
            instr_q    <= instr_d;
            count_q    <= count_d;
            mem_req_q  <= mem_req_d;
            valid_q    <= valid_d;
        end
    end

    assign mem_req     = mem_req_q;
    assign mem_addr    = mem_addr_q;
    assign instr       = instr_q;
    assign instr_valid = valid_q;
    assign pc_out      = pc_out_q;
    assign instr_count = count_q;

endmodule

// File: tb/tb_instr_fetch.sv
// Bench for instr_fetch: a reactive memory/decode driver feeds an expectation queue,
// and an independent monitor checks every cycle against a PC/count reference model.
module tb_instr_fetch;

    localparam int unsigned AW     = 32;
    localparam logic [31:0] RST_PC = 32'h0;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc;
    } exp_t;

    typedef struct {
        logic        pcsrc;
        logic [31:0] imm;
        int          hold;
    } cmd_t;

    logic          clk = 1'b0;
    logic          rst;
    logic          mem_req;
    logic [AW-1:0] mem_addr;
    logic          mem_ack;
    logic [31:0]   mem_rdata;
    logic [31:0]   instr;
    logic          instr_valid;
    logic          instr_ready;
    logic [AW-1:0] pc_out;
    logic          PCsrc;
    logic [AW-1:0] ImmOp;
    logic [31:0]   instr_count;

    instr_fetch #(.ADDRESS_WIDTH(AW), .RESET_PC(RST_PC)) dut (
        .clk(clk), .rst(rst),
        .mem_req(mem_req), .mem_addr(mem_addr), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
        .instr(instr), .instr_valid(instr_valid), .instr_ready(instr_ready),
        .pc_out(pc_out), .PCsrc(PCsrc), .ImmOp(ImmOp), .instr_count(instr_count)
    );

    always #5 clk = ~clk;

    int          n_checks = 0;
    int          n_pass   = 0;
    exp_t        exp_q[$];
    cmd_t        cmd_q[$];
    int          lat_q[$];
    logic [31:0] pc_log[$];
    logic [31:0] model_pc;
    logic [31:0] model_count;
    bit          model_rst;
    bit          mon_en;
    bit          acked_now;
    bit          req_seen;
    bit          prev_valid;
    int          lat_cnt;
    int          hold_cnt;
    logic [31:0] exp_pcs [12] = '{32'h0, 32'h4, 32'h8, 32'hC, 32'h10, 32'h8,
                                  32'h10, 32'h14, 32'h10, 32'h14, 32'hFFFF_FFFC, 32'h0};

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (a == 32'h0) return 32'h0010_0093;
        return {a[15:0], ~a[31:16]} ^ 32'h5A5A_1234;
    endfunction

    function automatic logic [31:0] rand_imm();
        logic [31:0] v;
        case ($urandom_range(0, 3))
            0:       v = 32'($urandom_range(0, 64));
            1:       v = -32'($urandom_range(0, 64));
            2:       v = $urandom();
            default: v = 32'h0;
        endcase
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    endtask

    task automatic add_cmd(input logic p, input logic [31:0] imm, input int hold, input int lat);
        cmd_t c;
        c.pcsrc = p;
        c.imm   = imm;
        c.hold  = hold;
        cmd_q.push_back(c);
        lat_q.push_back(lat);
    endtask

    // One cycle of memory + decode stimulus, applied just after the rising edge.
    task automatic drive_cycle();
        cmd_t c;
        @(posedge clk); #1;
        acked_now = 1'b0;
        if (mem_req) begin
            if (!req_seen) begin
                req_seen = 1'b1;
                if (lat_q.size() != 0) lat_cnt = lat_q.pop_front();
                else                   lat_cnt = int'($urandom_range(0, 3));
            end
            if (lat_cnt == 0) begin
                mem_ack   = 1'b1;
                mem_rdata = mem_word(mem_addr);
                exp_q.push_back({mem_word(model_pc), model_pc});
                acked_now = 1'b1;
                req_seen  = 1'b0;
            end else begin
                lat_cnt--;
                mem_ack   = 1'b0;
                mem_rdata = $urandom();
            end
        end else begin
            req_seen  = 1'b0;
            mem_ack   = ($urandom_range(0, 3) == 0);
            mem_rdata = 32'hDEAD_BEEF;
        end

        if (instr_valid) begin
            if (!prev_valid) begin
                if (cmd_q.size() != 0) hold_cnt = cmd_q[0].hold;
                else                   hold_cnt = int'($urandom_range(0, 3));
            end
            if (hold_cnt == 0) begin
                instr_ready = 1'b1;
                if (cmd_q.size() != 0) begin
                    c     = cmd_q.pop_front();
                    PCsrc = c.pcsrc;
                    ImmOp = c.imm;
                end else begin
                    PCsrc = 1'($urandom_range(0, 1));
                    ImmOp = rand_imm();
                end
            end else begin
                hold_cnt--;
                instr_ready = 1'b0;
                PCsrc       = 1'($urandom_range(0, 1));
                ImmOp       = $urandom();
            end
        end else begin
            instr_ready = 1'($urandom_range(0, 1));
            PCsrc       = 1'($urandom_range(0, 1));
            ImmOp       = $urandom();
        end
        prev_valid = instr_valid;
    endtask

    // Reset pulse of one cycle with a memory ack in the reset cycle and the cycle after.
    task automatic do_reset();
        @(posedge clk); #1;
        rst = 1'b0; mem_ack = 1'b1; mem_rdata = 32'hDEAD_BEEF; instr_ready = 1'b1;
        acked_now = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1; mem_ack = 1'b1; mem_rdata = 32'hDEAD_BEEF; instr_ready = 1'b1;
        acked_now = 1'b0; req_seen = 1'b0; prev_valid = 1'b0;
        lat_q.delete();
    endtask

    // Monitor + reference model: sampled on the falling edge.
    exp_t        m_e;
    logic [31:0] m_nxt;
    bit          m_ev;
    bit          m_er;
    initial begin
        wait (mon_en);
        forever begin
            @(negedge clk);
            if (model_rst) begin
                exp_q.delete();
                model_pc    = RST_PC;
                model_count = 32'h0;
                chk("rst_mem_req",     32'(mem_req),     32'h0);
                chk("rst_mem_addr",    mem_addr,         32'h0);
                chk("rst_instr_valid", 32'(instr_valid), 32'h0);
                chk("rst_instr",       instr,            32'h0);
                chk("rst_pc_out",      pc_out,           32'h0);
                chk("rst_instr_count", instr_count,      32'h0);
            end else begin
                m_ev = (exp_q.size() != 0) && !acked_now;
                m_er = (exp_q.size() == 0) || acked_now;
                chk("mem_req",     32'(mem_req),     32'(m_er));
                chk("mem_addr",    mem_addr,         m_er ? model_pc : 32'h0);
                chk("instr_valid", 32'(instr_valid), 32'(m_ev));
                chk("instr_count", instr_count,      model_count);
                if (m_ev) begin
                    chk("instr",  instr,  exp_q[0].instr);
                    chk("pc_out", pc_out, exp_q[0].pc);
                    if (instr_ready) begin
                        m_e   = exp_q.pop_front();
                        m_nxt = PCsrc ? (m_e.pc + ImmOp) : (m_e.pc + 32'd4);
                        model_pc    = {m_nxt[31:2], 2'b00};
                        model_count = model_count + 32'd1;
                        pc_log.push_back(m_e.pc);
                    end
                end
            end
            model_rst = (rst == 1'b0);
        end
    end

    initial begin
        rst = 1'b0; mem_ack = 1'b0; mem_rdata = 32'h0;
        instr_ready = 1'b0; PCsrc = 1'b0; ImmOp = 32'h0;
        model_rst = 1'b1; model_pc = RST_PC; model_count = 32'h0;
        mon_en = 1'b0; acked_now = 1'b0; req_seen = 1'b0; prev_valid = 1'b0;
        lat_cnt = 0; hold_cnt = 0;

        // pcsrc, imm, hold cycles before ready, memory latency
        add_cmd(1'b0, 32'h0,         0, 1);
        add_cmd(1'b0, 32'h0,         4, 3);
        add_cmd(1'b0, 32'h0,         0, 0);
        add_cmd(1'b0, 32'h0,         1, 1);
        add_cmd(1'b1, 32'hFFFF_FFF8, 0, 0);
        add_cmd(1'b1, 32'h8,         0, 2);
        add_cmd(1'b0, 32'h123,       2, 0);
        add_cmd(1'b1, 32'hFFFF_FFFC, 0, 1);
        add_cmd(1'b1, 32'h6,         0, 0);
        add_cmd(1'b1, 32'hFFFF_FFE8, 0, 0);
        add_cmd(1'b0, 32'h0,         0, 3);
        add_cmd(1'b1, 32'h3,         0, 1);

        repeat (3) @(posedge clk);
        #1;
        mon_en = 1'b1; rst = 1'b1; mem_ack = 1'b1; mem_rdata = 32'hDEAD_BEEF;

        for (int i = 0; i < 300 && !(cmd_q.size() == 0 && pc_log.size() >= 12); i++)
            drive_cycle();
        chk("directed_cmds_left", 32'(cmd_q.size()), 32'h0);
        chk("directed_accepts",   32'(pc_log.size() >= 12), 32'h1);
        for (int i = 0; i < 12 && i < pc_log.size(); i++)
            chk($sformatf("directed_pc_%0d", i), pc_log[i], exp_pcs[i]);

        repeat (1500) drive_cycle();

        // Park the DUT in a long memory wait, then pulse reset.
        lat_q.push_back(6);
        for (int i = 0; i < 40 && lat_q.size() != 0; i++)
            drive_cycle();
        chk("reset_in_wait_setup", 32'(lat_q.size()), 32'h0);
        do_reset();

        repeat (500) drive_cycle();

        @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
